// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: datapath width, FSM states,
// the latched ALU operation record and the requester-id width helper.
package alu_arb_pkg;

  localparam int NBITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic [1:0]       f;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic             c_in;
  } alu_op_t;

  // Width of an encoded requester id; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response bus of the ALU arbiter.
// Optional feature macro: ARB_FLAGS_EN adds rsp_zero / rsp_neg.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2
);

  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [1:0]       req_f    [NREQ];
  logic [NBITS-1:0] req_a    [NREQ];
  logic [NBITS-1:0] req_b    [NREQ];
  logic [NREQ-1:0]  req_c_in;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [NBITS-1:0] rsp_y;
  logic             rsp_c_out;
`ifdef ARB_FLAGS_EN
  logic             rsp_zero;
  logic             rsp_neg;
`endif

  modport slave (
    input  req_valid, req_f, req_a, req_b, req_c_in, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_c_out
`ifdef ARB_FLAGS_EN
    , rsp_zero, rsp_neg
`endif
  );

  modport master (
    output req_valid, req_f, req_a, req_b, req_c_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_c_out
`ifdef ARB_FLAGS_EN
    , rsp_zero, rsp_neg
`endif
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping NREQ-1 -> 0. Emits a one-hot grant and its encoded id.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id
);

  logic        w_found;
  int unsigned w_idx;

  // Scan from the pointer and grant the first pending requester.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    o_grant = '0;
    o_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = (i + 32'(i_ptr)) % NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one datapath ALU between NREQ requesters. Round-robin grant in IDLE,
// operands held stable through EXEC for ALU_LAT+1 cycles, result held in RESP
// until accepted. Optional feature macro: ARB_FLAGS_EN (rsp_zero / rsp_neg).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_arbiter_if.slave     bus,
  output logic [1:0]       alu_f,
  output logic [NBITS-1:0] alu_a,
  output logic [NBITS-1:0] alu_b,
  output logic             alu_c_in,
  input  logic [NBITS-1:0] alu_y,
  input  logic             alu_c_out
);

  localparam int IDW = id_w(NREQ);

  arb_state_t       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [3:0]       r_cnt;
  alu_op_t          r_op;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [NBITS-1:0] r_rsp_y;
  logic             r_rsp_c;
`ifdef ARB_FLAGS_EN
  logic             r_rsp_zero;
  logic             r_rsp_neg;
`endif

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_next_ptr;
  logic             w_hs;
  alu_op_t          w_req_op;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_gnt_id)
  );

  assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_hs          = (r_state == IDLE) && (|w_grant);
  assign w_next_ptr    = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
  assign w_req_op      = '{f:    bus.req_f[w_gnt_id],
                           a:    bus.req_a[w_gnt_id],
                           b:    bus.req_b[w_gnt_id],
                           c_in: bus.req_c_in[w_gnt_id]};

  assign alu_f    = r_op.f;
  assign alu_a    = r_op.a;
  assign alu_b    = r_op.b;
  assign alu_c_in = r_op.c_in;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_c_out = r_rsp_c;
`ifdef ARB_FLAGS_EN
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_neg   = r_rsp_neg;
`endif

  // Arbitration FSM: grant and latch in IDLE, wait out ALU latency, hold response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_rsp_c     <= 1'b0;
`ifdef ARB_FLAGS_EN
      r_rsp_zero  <= 1'b0;
      r_rsp_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_op    <= w_req_op;
            r_id    <= w_gnt_id;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == 4'(ALU_LAT)) begin
            r_rsp_y     <= alu_y;
            r_rsp_c     <= alu_c_out;
            r_rsp_id    <= r_id;
`ifdef ARB_FLAGS_EN
            r_rsp_zero  <= (alu_y == '0);
            r_rsp_neg   <= alu_y[NBITS-1];
`endif
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: two instances (ALU_LAT=0 and ALU_LAT=3),
// each with an a+b+c_in ALU model. Optional macro: ARB_FLAGS_EN.
module tb_alu_arbiter;

  typedef struct {
    logic        id;
    logic [15:0] y;
    logic        c;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;

  logic [1:0]  t_valid     [2];
  logic [1:0]  t_f         [2][2];
  logic [15:0] t_a         [2][2];
  logic [15:0] t_b         [2][2];
  logic [1:0]  t_c         [2];
  logic        t_rsp_ready [2];
  logic        t_rst_n     [2];

  logic [1:0]  w_ready     [2];
  logic        w_rsp_valid [2];
  logic        w_rsp_id    [2];
  logic [15:0] w_rsp_y     [2];
  logic        w_rsp_c     [2];
  logic [15:0] w_alu_a     [2];
`ifdef ARB_FLAGS_EN
  logic        w_zero      [2];
  logic        w_neg       [2];
`endif

  exp_t sb_q [2][$];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int LAT = (d == 0) ? 0 : 3;

    alu_arbiter_if #(.NREQ(2)) bus ();
    logic [1:0]  alu_f;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_c_in, alu_c_out;
    logic [16:0] w_sum;

    assign bus.req_valid = t_valid[d];
    assign bus.req_c_in  = t_c[d];
    assign bus.rsp_ready = t_rsp_ready[d];
    for (genvar r = 0; r < 2; r++) begin : g_req
      assign bus.req_f[r] = t_f[d][r];
      assign bus.req_a[r] = t_a[d][r];
      assign bus.req_b[r] = t_b[d][r];
    end

    assign w_ready[d]     = bus.req_ready;
    assign w_rsp_valid[d] = bus.rsp_valid;
    assign w_rsp_id[d]    = bus.rsp_id;
    assign w_rsp_y[d]     = bus.rsp_y;
    assign w_rsp_c[d]     = bus.rsp_c_out;
    assign w_alu_a[d]     = alu_a;
`ifdef ARB_FLAGS_EN
    assign w_zero[d]      = bus.rsp_zero;
    assign w_neg[d]       = bus.rsp_neg;
`endif

    alu_arbiter #(.NREQ(2), .ALU_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset_n   (t_rst_n[d]),
      .bus       (bus),
      .alu_f     (alu_f),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c_in  (alu_c_in),
      .alu_y     (alu_y),
      .alu_c_out (alu_c_out)
    );

    // ALU model: y = a + b + c_in, delayed by LAT clock edges.
    assign w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_c_in};
    if (LAT == 0) begin : g_comb
      assign {alu_c_out, alu_y} = w_sum;
    end else begin : g_pipe
      logic [16:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= w_sum;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign {alu_c_out, alu_y} = pipe[LAT-1];
    end

    // Monitor: pop and compare on each new response, check hold under backpressure.
    initial begin
      logic        prev_v;
      logic        prev_r;
      logic [15:0] held_y;
      logic        held_id;
      exp_t        e;
      prev_v = 1'b0;
      prev_r = 1'b1;
      held_y = '0;
      held_id = 1'b0;
      forever begin
        @(negedge clk);
        if (mon_en && t_rst_n[d] === 1'b1) begin
          chk("ready_without_valid", 32'(w_ready[d] & ~t_valid[d]), 32'd0);
          if (w_rsp_valid[d] === 1'b1) begin
            chk("ready_during_resp", 32'(w_ready[d]), 32'd0);
            if (!prev_v) begin
              if (sb_q[d].size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
              end else begin
                e = sb_q[d].pop_front();
                chk("rsp_id", 32'(w_rsp_id[d]), 32'(e.id));
                chk("rsp_y", 32'(w_rsp_y[d]), 32'(e.y));
                chk("rsp_c_out", 32'(w_rsp_c[d]), 32'(e.c));
                chk("rsp_latency", 32'(cyc), 32'(e.cyc + LAT + 1));
`ifdef ARB_FLAGS_EN
                chk("rsp_zero", 32'(w_zero[d]), 32'(e.y == 16'h0000));
                chk("rsp_neg", 32'(w_neg[d]), 32'(e.y[15]));
`endif
              end
              held_y  = w_rsp_y[d];
              held_id = w_rsp_id[d];
            end else if (!prev_r) begin
              chk("rsp_y_stable", 32'(w_rsp_y[d]), 32'(held_y));
              chk("rsp_id_stable", 32'(w_rsp_id[d]), 32'(held_id));
            end
          end
          prev_v = w_rsp_valid[d];
          prev_r = t_rsp_ready[d];
        end else begin
          prev_v = 1'b0;
          prev_r = 1'b1;
        end
      end
    end
  end

  task automatic load(input int d, input int r, input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    t_a[d][r]     = a;
    t_b[d][r]     = b;
    t_c[d][r]     = c;
    t_f[d][r]     = 2'(r + 1);
    t_valid[d][r] = 1'b1;
  endtask

  // Wait (bounded) for a grant, check who got it, push the expected response.
  task automatic wait_grant(input int d, input int id, input logic [15:0] ey, input logic ec,
                            output int hs, output int n);
    exp_t e;
    n  = 0;
    hs = 0;
    @(negedge clk);
    while (w_ready[d] == 2'b00 && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (w_ready[d] == 2'b00) begin
      chk("grant_timeout", 32'd1, 32'd0);
      return;
    end
    chk("grant_onehot", 32'(w_ready[d]), 32'(2'b01 << id));
    hs    = cyc + 1;
    e.id  = id[0];
    e.y   = ey;
    e.c   = ec;
    e.cyc = hs;
    sb_q[d].push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb_q[d].size() != 0 || w_rsp_valid[d] === 1'b1) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (sb_q[d].size() != 0 || w_rsp_valid[d] === 1'b1) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, prev_hs, n;
    int          rr_id [4] = '{0, 1, 0, 1};
    logic [15:0] rr_a  [4] = '{16'h8000, 16'h0005, 16'h7FFF, 16'hFFFE};
    logic [15:0] rr_b  [4] = '{16'h8000, 16'h0007, 16'h0001, 16'h0001};
    logic        rr_c  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] rr_y  [4] = '{16'h0001, 16'h000D, 16'h8000, 16'h0000};
    logic        rr_co [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int d = 0; d < 2; d++) begin
      t_valid[d] = '0;
      t_c[d] = '0;
      t_rsp_ready[d] = 1'b1;
      t_rst_n[d] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        t_f[d][r] = '0;
        t_a[d][r] = '0;
        t_b[d][r] = '0;
      end
    end

    // Reset asserted at cycle 3.
    repeat (3) @(posedge clk);
    #1;
    t_rst_n[0] = 1'b0;
    t_rst_n[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(w_ready[d]), 32'd0);
      chk("reset_rsp_valid", 32'(w_rsp_valid[d]), 32'd0);
      chk("reset_rsp_y", 32'(w_rsp_y[d]), 32'd0);
      chk("reset_alu_a", 32'(w_alu_a[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    t_rst_n[0] = 1'b1;
    t_rst_n[1] = 1'b1;
    mon_en = 1'b1;

    // Single op, ALU_LAT=0: 00FF + 0001 = 0100.
    @(posedge clk); #1;
    load(0, 0, 16'h00FF, 16'h0001, 1'b0);
    wait_grant(0, 0, 16'h0100, 1'b0, hs, n);
    t_valid[0][0] = 1'b0;
    wait_drain(0);

    // Backpressure: req1 op held 5 cycles while req0 waits.
    @(posedge clk); #1;
    t_rsp_ready[0] = 1'b0;
    load(0, 1, 16'h1234, 16'h1111, 1'b0);
    wait_grant(0, 1, 16'h2345, 1'b0, hs, n);
    t_valid[0][1] = 1'b0;
    load(0, 0, rr_a[0], rr_b[0], rr_c[0]);
    n = 0;
    @(negedge clk);
    while (w_rsp_valid[0] !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 32'(w_ready[0]), 32'd0);
      chk("bp_rsp_valid", 32'(w_rsp_valid[0]), 32'd1);
      chk("bp_rsp_y", 32'(w_rsp_y[0]), 32'h2345);
      chk("bp_rsp_id", 32'(w_rsp_id[0]), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    t_rsp_ready[0] = 1'b1;

    // Round robin with both requesters pending: 0,1,0,1 at one op per 3 cycles.
    prev_hs = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(0, rr_id[i], rr_y[i], rr_co[i], hs, n);
      if (i == 0) begin
        chk("grant_after_accept", 32'(n), 32'd1);
        load(0, 1, rr_a[1], rr_b[1], rr_c[1]);
      end else begin
        chk("rr_spacing", 32'(hs - prev_hs), 32'd3);
      end
      prev_hs = hs;
      if (i + 2 < 4) load(0, rr_id[i], rr_a[i+2], rr_b[i+2], rr_c[i+2]);
      else t_valid[0][rr_id[i]] = 1'b0;
    end
    wait_drain(0);

    // Carry and latency, ALU_LAT=3: FFFF + 0001 + 1 = 1_0001.
    @(posedge clk); #1;
    load(1, 0, 16'hFFFF, 16'h0001, 1'b1);
    wait_grant(1, 0, 16'h0001, 1'b1, hs, n);
    t_valid[1][0] = 1'b0;
    wait_drain(1);

    // Reset at cnt=1 on the ALU_LAT=3 instance: op discarded, pointer back to 0.
    @(posedge clk); #1;
    load(1, 0, 16'h0002, 16'h0003, 1'b0);
    wait_grant(1, 0, 16'h0005, 1'b0, hs, n);
    @(posedge clk); #1;
    t_rst_n[1] = 1'b0;
    sb_q[1].delete();
    t_valid[1] = '0;
    #1;
    chk("midexec_rsp_valid", 32'(w_rsp_valid[1]), 32'd0);
    chk("midexec_alu_a", 32'(w_alu_a[1]), 32'd0);
    repeat (2) @(negedge clk);
    t_rst_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(w_rsp_valid[1]), 32'd0);
    end
    @(posedge clk); #1;
    load(1, 0, 16'h0010, 16'h0020, 1'b0);
    load(1, 1, 16'h0001, 16'h0001, 1'b0);
    wait_grant(1, 0, 16'h0030, 1'b0, hs, n);
    t_valid[1][0] = 1'b0;
    wait_grant(1, 1, 16'h0002, 1'b0, hs, n);
    t_valid[1][1] = 1'b0;
    wait_drain(1);

    repeat (3) @(negedge clk);
    chk("sb0_empty", 32'(sb_q[0].size()), 32'd0);
    chk("sb1_empty", 32'(sb_q[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
